// File: rtl/voice_scheduler.sv
// voice_scheduler: allocates note requests to three synth voices and retires them by beat count.
// Optional feature macro: VOICE_SCHED_STEAL_EN (when all voices are busy, preempt the voice
// with the least remaining duration instead of dropping the request).
// Ports:
//   clk, reset     system clock, asynchronous active-high reset
//   clear          synchronous stop-all; deactivates every voice, abandons any in-flight request
//   note_req       request strobe, accepted only while req_ready=1
//   note_id        note to play, sampled on acceptance
//   note_dur       duration in beats, sampled on acceptance (0 plays as 1)
//   req_ready      scheduler idle and able to accept a request
//   voice_load     one-hot, one-cycle load strobe for the target voice
//   voice_note     per-voice current note, voice i at [i*NOTE_W +: NOTE_W]
//   voice_active   voice currently sounding
//   beat           one-cycle tick every BEAT_COUNT clocks
//   steal          one-cycle pulse with voice_load when a busy voice was preempted
//   req_drop       one-cycle pulse when a request found no voice
module voice_scheduler #(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int BEAT_COUNT = 1000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         note_req,
    input  logic [NOTE_W-1:0]            note_id,
    input  logic [DUR_W-1:0]             note_dur,
    output logic                         req_ready,
    output logic [NUM_VOICES-1:0]        voice_load,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic                         beat,
    output logic                         steal,
    output logic                         req_drop
);
    localparam int CNT_W = (BEAT_COUNT > 1) ? $clog2(BEAT_COUNT) : 1;
    localparam int VI_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [1:0] {IDLE, ALLOC, LOAD} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [NOTE_W-1:0]     req_note;
    logic [DUR_W-1:0]      req_dur;
    logic [DUR_W-1:0]      remaining [NUM_VOICES];
    logic [NUM_VOICES-1:0] busy;
    logic [NUM_VOICES-1:0] hit;
    logic [VI_W-1:0]       target;
    logic                  found;
    logic                  stolen;
    logic                  do_load;
    logic                  do_drop;

    assign beat      = cnt == CNT_W'(BEAT_COUNT - 1);
    assign req_ready = state == IDLE;

    // A voice whose last beat lands this cycle is already considered free, so
    // selection sees expiry before allocation.
    always_comb begin
        busy = '0;
        hit  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            busy[i] = voice_active[i] && !(beat && remaining[i] == DUR_W'(1));
            hit[i]  = busy[i] && voice_note[i*NOTE_W +: NOTE_W] == req_note;
        end
    end

    // Later loops override earlier ones: retrigger beats free voice beats steal.
    always_comb begin
        target = '0;
        found  = 1'b0;
        stolen = 1'b0;
        for (int i = NUM_VOICES - 1; i >= 0; i--)
            if (!busy[i]) begin
                target = VI_W'(i);
                found  = 1'b1;
            end
        for (int i = NUM_VOICES - 1; i >= 0; i--)
            if (hit[i]) begin
                target = VI_W'(i);
                found  = 1'b1;
            end
`ifdef VOICE_SCHED_STEAL_EN
        if (!found) begin
            found  = 1'b1;
            stolen = 1'b1;
            target = '0;
            for (int i = 1; i < NUM_VOICES; i++)
                if (remaining[i] < remaining[target]) target = VI_W'(i);
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        do_drop   = 1'b0;
        if (clear) state_nxt = IDLE;
        else begin
            case (state)
                IDLE:    state_nxt = note_req ? ALLOC : IDLE;
                ALLOC: begin
                    do_load   = found;
                    do_drop   = !found;
                    state_nxt = found ? LOAD : IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nxt;

    // The voice registers are written on the ALLOC->LOAD edge so they are
    // visible together with the load strobe; during the LOAD cycle the strobe
    // shields the fresh duration from a coincident beat.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt          <= '0;
            req_note     <= '0;
            req_dur      <= '0;
            voice_load   <= '0;
            voice_note   <= '0;
            voice_active <= '0;
            steal        <= 1'b0;
            req_drop     <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) remaining[i] <= '0;
        end else begin
            cnt        <= beat ? '0 : cnt + CNT_W'(1);
            voice_load <= '0;
            steal      <= do_load && stolen;
            req_drop   <= do_drop;
            if (state == IDLE && note_req && !clear) begin
                req_note <= note_id;
                req_dur  <= (note_dur == '0) ? DUR_W'(1) : note_dur;
            end
            for (int i = 0; i < NUM_VOICES; i++)
                if (clear) begin
                    voice_active[i] <= 1'b0;
                    remaining[i]    <= '0;
                end else if (do_load && target == VI_W'(i)) begin
                    voice_load[i]                   <= 1'b1;
                    voice_active[i]                 <= 1'b1;
                    remaining[i]                    <= req_dur;
                    voice_note[i*NOTE_W +: NOTE_W]  <= req_note;
                end else if (beat && voice_active[i] && remaining[i] != '0 && !voice_load[i]) begin
                    remaining[i] <= remaining[i] - DUR_W'(1);
                    if (remaining[i] == DUR_W'(1)) voice_active[i] <= 1'b0;
                end
        end
endmodule

// File: tb/tb_voice_scheduler.sv
// tb_voice_scheduler: randomized scoreboard bench for voice_scheduler with a beat-counting reference model.
module tb_voice_scheduler;
    localparam int BC  = 4;
    localparam int NV  = 3;
    localparam int BIG = 1 << 30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        note_req = 1'b0;
    logic [5:0]  note_id = '0;
    logic [5:0]  note_dur = '0;
    logic        req_ready;
    logic [2:0]  voice_load;
    logic [17:0] voice_note;
    logic [2:0]  voice_active;
    logic        beat;
    logic        steal;
    logic        req_drop;

    typedef struct {
        int cyc;
        int load;
        int st;
        int drop;
    } ev_t;

    ev_t q[$];
    ev_t mon_e;
    int  cyc = 0;
    int  checks = 0;
    int  passes = 0;
    int  exp_lat = 0;
    bit  started = 1'b0;
    // Each voice keeps its previous and current assignment: start cycle,
    // duration, kill cycle (clear) and note.
    int  l0[NV], l1[NV], d0[NV], d1[NV], k0[NV], k1[NV], n0[NV], n1[NV];

    voice_scheduler #(.NUM_VOICES(3), .NOTE_W(6), .DUR_W(6), .BEAT_COUNT(BC)) dut (
        .clk(clk), .reset(reset), .clear(clear), .note_req(note_req),
        .note_id(note_id), .note_dur(note_dur), .req_ready(req_ready),
        .voice_load(voice_load), .voice_note(voice_note), .voice_active(voice_active),
        .beat(beat), .steal(steal), .req_drop(req_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset)
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    // beats occur on cycles k with k % BC == BC-1
    function automatic int beats_in(input int a, input int b);
        return (b < a) ? 0 : (b + 1) / BC - a / BC;
    endfunction

    // beats remaining for voice v as seen during cycle t
    function automatic int rem_at(input int v, input int t);
        int l, d, k, r;
        if (t >= l1[v]) begin l = l1[v]; d = d1[v]; k = k1[v]; end
        else begin l = l0[v]; d = d0[v]; k = k0[v]; end
        if (t < l || t >= k) return 0;
        r = d - beats_in(l + 1, t - 1);
        return (r < 0) ? 0 : r;
    endfunction

    function automatic int note_at(input int v, input int t);
        return (t >= l1[v]) ? n1[v] : n0[v];
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            l0[v] = 0; l1[v] = 0; d0[v] = 0; d1[v] = 0;
            k0[v] = BIG; k1[v] = BIG; n0[v] = 0; n1[v] = 0;
        end
    endtask

    task automatic model_kill(input int t);
        for (int v = 0; v < NV; v++) begin
            k0[v] = t;
            k1[v] = t;
        end
    endtask

    // Decide the allocation for a request accepted in cycle n (ALLOC in n+1).
    task automatic predict(input int n, input int id, input int dur);
        int a, t, st;
        a = n + 1; t = -1; st = 0;
        for (int v = NV - 1; v >= 0; v--) if (rem_at(v, a + 1) == 0) t = v;
        for (int v = NV - 1; v >= 0; v--) if (rem_at(v, a + 1) > 0 && note_at(v, a) == id) t = v;
`ifdef VOICE_SCHED_STEAL_EN
        if (t < 0) begin
            t = 0; st = 1;
            for (int v = 1; v < NV; v++) if (rem_at(v, a) < rem_at(t, a)) t = v;
        end
`endif
        if (t < 0) begin
            q.push_back('{n + 2, 0, 0, 1});
            exp_lat = 2;
        end else begin
            l0[t] = l1[t]; d0[t] = d1[t]; k0[t] = k1[t]; n0[t] = n1[t];
            l1[t] = n + 2; d1[t] = (dur == 0) ? 1 : dur; k1[t] = BIG; n1[t] = id;
            q.push_back('{n + 2, 1 << t, st, 0});
            exp_lat = 3;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int g;
        g = 0;
        while (!req_ready && g < 20) begin tick(); g++; end
        chk("ready_wait", int'(req_ready), 1);
    endtask

    // note_req is held one extra cycle into ALLOC, where it must be ignored.
    task automatic req(input int id, input int dur);
        int n, g;
        wait_ready();
        note_id = 6'(id); note_dur = 6'(dur); note_req = 1'b1; n = cyc;
        predict(n, id, dur);
        tick();
        chk("busy_in_alloc", int'(req_ready), 0);
        tick();
        note_req = 1'b0;
        g = 0;
        while (!req_ready && g < 10) begin tick(); g++; end
        chk("ready_latency", cyc - n, exp_lat);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        model_kill(cyc + 1);
        tick();
        clear = 1'b0;
        chk("clear_ready", int'(req_ready), 1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_voice_load", int'(voice_load), 0);
        chk("rst_voice_note", int'(voice_note), 0);
        chk("rst_voice_active", int'(voice_active), 0);
        chk("rst_beat", int'(beat), 0);
        chk("rst_steal", int'(steal), 0);
        chk("rst_req_drop", int'(req_drop), 0);
    endtask

    always @(negedge clk)
        if (!reset && started) begin
            chk("beat", int'(beat), int'(cyc % BC == BC - 1));
            for (int v = 0; v < NV; v++) begin
                chk("voice_active", int'(voice_active[v]), int'(rem_at(v, cyc) > 0));
                chk("voice_note", int'(voice_note[v*6 +: 6]), note_at(v, cyc));
            end
            while (q.size() > 0 && q[0].cyc < cyc) begin
                chk("sb_missing_event_cycle", cyc, q[0].cyc);
                mon_e = q.pop_front();
            end
            if (voice_load != 0 || req_drop || steal) begin
                if (q.size() == 0) chk("sb_unexpected_event", int'({steal, req_drop, voice_load}), 0);
                else begin
                    mon_e = q.pop_front();
                    chk("sb_event_cycle", cyc, mon_e.cyc);
                    chk("sb_voice_load", int'(voice_load), mon_e.load);
                    chk("sb_steal", int'(steal), mon_e.st);
                    chk("sb_req_drop", int'(req_drop), mon_e.drop);
                end
            end
        end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        reset = 1'b0;
        started = 1'b1;
        repeat (9) tick();
        req(10, 2);
        repeat (14) tick();
        do_clear();
        req(5, 8);
        req(6, 8);
        req(7, 8);
        req(6, 3);
        req(9, 4);
        repeat (40) tick();
        // load lands on a beat cycle
        wait_ready();
        req(20, 7);
        while (cyc % BC != 1) tick();
        req(21, 5);
        while (cyc % BC != 1) tick();
        req(22, 0);
        req(23, 6);
        repeat (30) tick();
        // clear during ALLOC abandons the request
        wait_ready();
        note_id = 6'd30; note_dur = 6'd3; note_req = 1'b1;
        tick();
        note_req = 1'b0;
        do_clear();
        chk("clear_alloc_active", int'(voice_active), 0);
        repeat (3) tick();
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 6)) tick();
            if ($urandom_range(0, 19) == 0) do_clear();
            else req(int'($urandom_range(0, 7)), int'($urandom_range(0, 12)));
        end
        // async reset during LOAD
        wait_ready();
        note_id = 6'd40; note_dur = 6'd5; note_req = 1'b1;
        tick();
        note_req = 1'b0;
        tick();
        chk("load_before_reset", int'(voice_load != 0), 1);
        reset = 1'b1;
        #1;
        chk_reset_vals();
        q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (8) tick();
        req(11, 1);
        repeat (8) tick();
        chk("sb_drain", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
